// File: rtl/regfile_dump_tx.sv
// Register-file dump transmitter: streams header, each register little-endian, optional XOR byte.
// Build option: define REGDUMP_CHECKSUM_EN to append the XOR checksum byte (CHK state).
`timescale 1ns/1ps
module regfile_dump_tx #(
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int unsigned LAST_REG = 31
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_dbg
);

  // Stream handshake: a byte moves on a cycle with tx_valid & tx_ready; once tx_valid
  // rises, tx_data is held and tx_valid stays high until that transfer; tx_data is 0 otherwise.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_LOAD   = 3'd2,
    S_SEND   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(LAST_REG);

`ifdef REGDUMP_CHECKSUM_EN
  localparam state_t AFTER_LAST = S_CHK;
`else
  localparam state_t AFTER_LAST = S_DONE;
`endif

  state_t      state, state_n;
  logic [4:0]  index, index_n;
  logic [1:0]  cnt, cnt_n;
  logic [31:0] shift, shift_n;
`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0]  chk, chk_n;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      index <= 5'd0;
      cnt   <= 2'd0;
      shift <= 32'd0;
`ifdef REGDUMP_CHECKSUM_EN
      chk   <= 8'd0;
`endif
    end else begin
      state <= state_n;
      index <= index_n;
      cnt   <= cnt_n;
      shift <= shift_n;
`ifdef REGDUMP_CHECKSUM_EN
      chk   <= chk_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    index_n  = index;
    cnt_n    = cnt;
    shift_n  = shift;
`ifdef REGDUMP_CHECKSUM_EN
    chk_n    = chk;
`endif
    tx_valid = 1'b0;
    tx_data  = 8'd0;
    done     = 1'b0;
    busy     = (state != S_IDLE);
    rd_addr  = index;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_HEADER;
          index_n = 5'd0;
`ifdef REGDUMP_CHECKSUM_EN
          chk_n   = 8'd0;
`endif
        end
      end
      S_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (tx_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
          chk_n   = chk ^ HEADER;
`endif
          state_n = S_LOAD;
        end
      end
      // Each register is captured here, in its own cycle: the dump is not atomic.
      S_LOAD: begin
        shift_n = rd_data;
        cnt_n   = 2'd0;
        state_n = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift[7:0];
        if (tx_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
          chk_n   = chk ^ shift[7:0];
`endif
          shift_n = {8'h00, shift[31:8]};
          cnt_n   = cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (index == LAST_IDX) begin
              state_n = AFTER_LAST;
            end else begin
              index_n = index + 5'd1;
              state_n = S_LOAD;
            end
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CHK: begin
        tx_valid = 1'b1;
        tx_data  = chk;
        if (tx_ready) state_n = S_DONE;
      end
`endif
      // index returns to 0 so rd_addr reads 0 throughout IDLE.
      S_DONE: begin
        done    = 1'b1;
        index_n = 5'd0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Directed bench for regfile_dump_tx: default 32-register instance plus a LAST_REG=3 instance.
`timescale 1ns/1ps
module tb_regfile_dump_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int DONE_C  = 163;
  localparam int SMALL_C = 23;
`else
  localparam int DONE_C  = 162;
  localparam int SMALL_C = 22;
`endif

  logic        resetn;
  logic        start, s_start;
  logic        tx_ready, s_tx_ready;
  logic [4:0]  rd_addr, s_rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data, s_tx_data;
  logic        tx_valid, s_tx_valid;
  logic        busy, s_busy, done, s_done;
  logic [2:0]  state_dbg, s_state_dbg;

  logic [31:0] regs [32];
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          dc;

  assign rd_data = regs[rd_addr];

  regfile_dump_tx dut (
    .clk(clk), .resetn(resetn), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  regfile_dump_tx #(.HEADER(8'hA5), .LAST_REG(3)) dut_small (
    .clk(clk), .resetn(resetn), .start(s_start), .rd_addr(s_rd_addr), .rd_data(32'h0),
    .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(s_tx_ready), .busy(s_busy),
    .done(s_done), .state_dbg(s_state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame from the bench's own register image.
  task automatic build_exp(input int last, input bit use_regs);
    logic [7:0]  c, b;
    logic [31:0] w;
    exp_q = {};
    exp_q.push_back(8'hA5);
    c = 8'hA5;
    for (int r = 0; r <= last; r++) begin
      w = use_regs ? regs[r] : 32'h0;
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        exp_q.push_back(b);
        c = c ^ b;
      end
    end
`ifdef REGDUMP_CHECKSUM_EN
    exp_q.push_back(c);
`endif
  endtask

  task automatic compare_stream(input string tag);
    logic [7:0] g, e;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check(tag, 32'(g), 32'(e));
    end
    exp_q = {};
    got_q = {};
  endtask

  // Cycle 0 is the cycle start is high; cycle k is observed at the k-th following negedge.
  task automatic run_frame(input bit sel, input int stall_lo, input int stall_hi,
                           input int pa, input int pb, input int wr_cyc,
                           input logic [31:0] wr_val, output int done_cyc);
    int   cyc;
    logic v, dn, bz;
    logic [7:0] d;
    got_q = {};
    done_cyc = -1;
    cyc = 0;
    @(negedge clk);
    if (sel) s_start = 1'b1; else start = 1'b1;
    while (cyc < 400 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (sel) s_start = (cyc == pa || cyc == pb);
      else     start   = (cyc == pa || cyc == pb);
      tx_ready   = !(cyc >= stall_lo && cyc <= stall_hi);
      s_tx_ready = tx_ready;
      v  = sel ? s_tx_valid : tx_valid;
      d  = sel ? s_tx_data  : tx_data;
      dn = sel ? s_done     : done;
      bz = sel ? s_busy     : busy;
      if (cyc == 1) check("busy_c1", 32'(bz), 32'h1);
      if (!v) check("quiet_data", 32'(d), 32'h0);
      if (cyc >= stall_lo && cyc <= stall_hi) begin
        check("stall_valid", 32'(v), 32'h1);
        check("stall_data", 32'(d), 32'h56);
      end
      if (v && tx_ready) got_q.push_back(d);
      if (dn) begin
        done_cyc = cyc;
        check("busy_in_done", 32'(bz), 32'h1);
      end
      if (cyc == wr_cyc) begin
        @(posedge clk);
        #1 regs[5] = wr_val;
      end
    end
    check("done_seen", 32'(done_cyc >= 0), 32'h1);
    @(negedge clk);
    start = 1'b0;
    s_start = 1'b0;
    tx_ready = 1'b1;
    s_tx_ready = 1'b1;
    check("busy_after", 32'(sel ? s_busy : busy), 32'h0);
    check("state_after", 32'(sel ? s_state_dbg : state_dbg), 32'h0);
    check("addr_after", 32'(sel ? s_rd_addr : rd_addr), 32'h0);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    s_start = 1'b0;
    tx_ready = 1'b1;
    s_tx_ready = 1'b1;
    foreach (regs[i]) regs[i] = 32'h0;
    regs[1]  = 32'h12345678;
    regs[31] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(tx_valid), 32'h0);
    check("rst_data",  32'(tx_data),  32'h0);
    check("rst_addr",  32'(rd_addr),  32'h0);
    check("rst_busy",  32'(busy),     32'h0);
    check("rst_done",  32'(done),     32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Basic frame with x1 and x31 populated.
    build_exp(31, 1'b1);
    run_frame(1'b0, 0, -1, -1, -1, -1, 32'h0, dc);
    if (got_q.size() > 8) begin
      check("t1_b0", 32'(got_q[0]), 32'hA5);
      check("t1_b5", 32'(got_q[5]), 32'h78);
      check("t1_b8", 32'(got_q[8]), 32'h12);
    end
`ifdef REGDUMP_CHECKSUM_EN
    if (got_q.size() > 129) check("t1_chk", 32'(got_q[129]), 32'h8F);
`endif
    compare_stream("t1_byte");
    check("t1_done_cyc", 32'(dc), 32'(DONE_C));

    // Backpressure on byte 0x56 (cycle 9) for three cycles.
    build_exp(31, 1'b1);
    run_frame(1'b0, 9, 11, -1, -1, -1, 32'h0, dc);
    compare_stream("t2_byte");
    check("t2_done_cyc", 32'(dc), 32'(DONE_C + 3));

    // Starts while busy are dropped; no second frame follows.
    build_exp(31, 1'b1);
    run_frame(1'b0, 0, -1, 10, 162, -1, 32'h0, dc);
    compare_stream("t3_byte");
    check("t3_done_cyc", 32'(dc), 32'(DONE_C));
    repeat (3) begin
      @(negedge clk);
      check("t3_no_refire", 32'(tx_valid), 32'h0);
      check("t3_idle_busy", 32'(busy), 32'h0);
    end
    build_exp(31, 1'b1);
    run_frame(1'b0, 0, -1, -1, -1, -1, 32'h0, dc);
    compare_stream("t3_fresh");

    // Asynchronous reset during the second byte of x7.
    regs[7] = 32'h0A0B0C07;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (38) @(negedge clk);
    check("t4_b1_valid", 32'(tx_valid), 32'h1);
    check("t4_b1_data",  32'(tx_data),  32'h0C);
    resetn = 1'b0;
    #1;
    check("t4_rst_valid", 32'(tx_valid), 32'h0);
    check("t4_rst_data",  32'(tx_data),  32'h0);
    check("t4_rst_addr",  32'(rd_addr),  32'h0);
    check("t4_rst_busy",  32'(busy),     32'h0);
    check("t4_rst_state", 32'(state_dbg), 32'h0);
    @(negedge clk);
    check("t4_hold_done",  32'(done),      32'h0);
    check("t4_hold_state", 32'(state_dbg), 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    build_exp(31, 1'b1);
    run_frame(1'b0, 0, -1, -1, -1, -1, 32'h0, dc);
    compare_stream("t4_after");
    check("t4_done_cyc", 32'(dc), 32'(DONE_C));

    // x5 is loaded at cycle 27; writes committing at the end of 27 or 28 are both too late.
    regs[5] = 32'h55555555;
    build_exp(31, 1'b1);
    run_frame(1'b0, 0, -1, -1, -1, 27, 32'hAAAA0001, dc);
    compare_stream("t5_wr_load");
    build_exp(31, 1'b1);
    run_frame(1'b0, 0, -1, -1, -1, 28, 32'hBBBB0002, dc);
    compare_stream("t5_wr_after");

    // LAST_REG=3 instance, all-zero registers.
    build_exp(3, 1'b0);
    run_frame(1'b1, 0, -1, -1, -1, -1, 32'h0, dc);
    compare_stream("t6_small");
    check("t6_done_cyc", 32'(dc), 32'(SMALL_C));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_dump_tx.md
# regfile_dump_tx

Register-file dump transmitter for the MiniMotorway core. On a start pulse it walks the integer register file through a dedicated read port and streams a framed byte sequence over a valid/ready byte interface. The frame is a header byte, then each register as four bytes little-endian, then an optional XOR checksum. It sits between the register file's debug read port and the UART/debug TX path.

## Interface
- `HEADER`, 8'hA5: first byte of every frame.
- `LAST_REG`, 31: index of the last register dumped, range 0..31; the dump always starts at x0.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: dump request, one-cycle pulse, sampled only in IDLE.
- `rd_addr` out 5: register index presented to the register-file read port.
- `rd_data` in 32: combinational read data for `rd_addr`.
- `tx_data` out 8: stream byte.
- `tx_valid` out 1: byte valid.
- `tx_ready` in 1: sink accepts the byte; a transfer occurs when `tx_valid & tx_ready`.
- `busy` out 1: high from the cycle after `start` is accepted until DONE is exited.
- `done` out 1: one-cycle pulse at the end of the frame.

## Operation
- Reset values: `rd_addr`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0. Internal state: FSM=IDLE, index=0, byte counter=0, checksum=0.
- **IDLE**:
  - `busy`=0.
  - `start`=1 → HEADER; index←0, checksum←0.
- **HEADER**:
  - `tx_valid`=1, `tx_data`=`HEADER`.
  - On transfer: checksum ^= `HEADER` → LOAD.
- **LOAD**: exactly one cycle.
  - `rd_addr`=index; shift register ← `rd_data`; byte counter←0 → SEND.
  - `tx_valid`=0 in this cycle.
- **SEND**:
  - `tx_valid`=1, `tx_data`=shift[7:0].
  - On transfer: checksum ^= byte; shift ← shift>>8; counter++.
  - After the 4th transfer: if index==`LAST_REG` → CHK (or DONE when checksum is compiled out); else index++ → LOAD.
- **CHK**:
  - `tx_valid`=1, `tx_data`=checksum.
  - On transfer → DONE.
- **DONE**: `done`=1 for one cycle → IDLE.
- `rd_addr` equals index in every state and is 0 in IDLE.
- Snapshot semantics: each register is sampled in its own LOAD cycle, so the dump is not atomic. A register written after its LOAD appears with its old value.
- Stream rule: once `tx_valid` is asserted, `tx_data` holds stable and `tx_valid` stays high until the transfer. `tx_data`=0 whenever `tx_valid`=0.
- `start` while `busy`: ignored and not queued. `start` in the DONE cycle: ignored.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). A partial frame is abandoned; no `done` is issued.

## Timing
- `start` accepted at cycle 0 → header valid at cycle 1.
- Each register costs 1 LOAD cycle + 4 SEND cycles with `tx_ready` held high.
- Frame length with checksum = 2 + 4·(`LAST_REG`+1) bytes; 130 bytes at the default.
- Minimum duration, `tx_ready`=1 throughout, default parameters: header at cycle 1, first LOAD at cycle 2, last data byte at cycle 161, checksum at cycle 162, `done` at cycle 163, IDLE at cycle 164.
- A new `start` is accepted no earlier than the first IDLE cycle after `done`.
- Each cycle `tx_ready`=0 while `tx_valid`=1 adds exactly one cycle.

## Configuration
- `REGDUMP_CHECKSUM_EN` defined: the CHK state exists and a trailing XOR byte is sent, covering the header and all data bytes.
- `REGDUMP_CHECKSUM_EN` undefined:
  - The CHK state and checksum register are removed; the frame ends after the last data byte.
  - The frame is 1 + 4·(`LAST_REG`+1) bytes; `done` follows the last data transfer by one cycle.

## Test plan
- Checksum on, all registers 0 except x1=0x12345678 and x31=0xDEADBEEF, `tx_ready`=1, pulse `start` → 130 bytes.
  - Bytes start A5, 00 00 00 00, 78 56 34 12 and end EF BE AD DE, 8F.
  - `done` at cycle 163.
- Backpressure: hold `tx_ready`=0 for 3 cycles while byte 0x56 is valid → `tx_data` stays 0x56 and `tx_valid` stays high; the frame completes 3 cycles late.
- `start` pulsed at cycles 10 and 162 of an active dump → no second frame; `busy` drops after `done`; the next `start` in IDLE gives a fresh frame beginning with A5.
- Deassert `resetn` mid-frame during the 2nd byte of x7 → next cycle all outputs are 0 and the FSM is in IDLE; after release, `start` produces a complete frame.
- `LAST_REG`=3, x0..x3=0, checksum on → 18 bytes: A5, sixteen 00, A5.
- `REGDUMP_CHECKSUM_EN` undefined → same pattern as above without the trailing byte: 17 bytes.
- Register write to x5 during its LOAD cycle vs. one cycle later → the dumped value is the pre-write value in both cases.
